// File: rtl/text_pkg.sv
// Shared definitions for the text-render blocks and the character ROM they share.
package text_pkg;

  localparam int CHAR_ADDR_W = 12;
  localparam int CHAR_CODE_W = 7;
  localparam logic [CHAR_CODE_W-1:0] CHAR_BLANK = 7'h20;

  typedef logic [CHAR_ADDR_W-1:0] char_addr_t;
  typedef logic [CHAR_CODE_W-1:0] char_code_t;

  typedef struct packed {
    char_addr_t xy;
    char_code_t code;
  } char_rom_pair_t;

  // Requester-id width; a single requester still needs one bit to carry a tag.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick among level requests, starting the search at a rotating pointer.
module rr_arbiter
  import text_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = id_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [N_REQ-1:0] i_req,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_id,
  output logic             o_valid
);

  localparam int SUM_W = ID_W + 1;

  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic [N_REQ-1:0] w_gnt;
  logic [ID_W-1:0]  w_id;
  logic             w_found;
  logic [SUM_W-1:0] w_sum;

  // NOTE: every output of a combinational block gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_gnt   = '0;
    w_id    = '0;
    w_found = 1'b0;
    w_sum   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + SUM_W'(k);
      if (w_sum >= SUM_W'(N_REQ)) begin
        w_sum = w_sum - SUM_W'(N_REQ);
      end
      if (!w_found && i_en && rst_n && i_req[w_sum[ID_W-1:0]]) begin
        w_found               = 1'b1;
        w_id                  = w_sum[ID_W-1:0];
        w_gnt[w_sum[ID_W-1:0]] = 1'b1;
      end
    end
  end

  assign w_ptr_nxt = (w_id == ID_W'(N_REQ - 1)) ? '0 : w_id + 1'b1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign o_gnt   = w_gnt;
  assign o_id    = w_id;
  assign o_valid = w_found;

endmodule

// File: rtl/char_rom_arbiter.sv
// Shares one registered character ROM port among N_REQ text renderers and routes
// each returned code back to the requester that issued the lookup.
module char_rom_arbiter
  import text_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = CHAR_ADDR_W,
  parameter int CODE_W  = CHAR_CODE_W,
  parameter int ROM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_char_xy,
  input  logic [CODE_W-1:0]       rom_char_code,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [CODE_W-1:0]       rsp_code,
  output logic                    busy
);

  localparam int ID_W  = id_width(N_REQ);
  localparam int DEPTH = ROM_LAT + 1;
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

  logic [N_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]   w_gnt_id;
  logic              w_gnt_valid;
  logic [ADDR_W-1:0] r_xy;
  tag_t              r_pipe [DEPTH];
  tag_t              w_last;
  logic              w_pipe_any;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic [CODE_W-1:0] r_rsp_code;
  logic              r_busy;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (en),
    .i_req   (req),
    .o_gnt   (w_gnt),
    .o_id    (w_gnt_id),
    .o_valid (w_gnt_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xy <= '0;
    end else if (w_gnt_valid) begin
      r_xy <= addr[int'(w_gnt_id)*ADDR_W +: ADDR_W];
    end
  end

  // NOTE: the tag pipe is cleared on reset because its valid bits decide whether a
  // response fires; stale entries would deliver codes for discarded lookups.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) begin
        r_pipe[s] <= '0;
      end
    end else begin
      r_pipe[0] <= '{valid: w_gnt_valid, id: w_gnt_id};
      for (int s = 1; s < DEPTH; s++) begin
        r_pipe[s] <= r_pipe[s-1];
      end
    end
  end

  assign w_last = r_pipe[DEPTH-1];

  always_comb begin
    w_pipe_any = 1'b0;
    for (int s = 0; s < DEPTH; s++) begin
      w_pipe_any = w_pipe_any | r_pipe[s].valid;
    end
  end

  // The last tag stage lines up with the ROM data, so code and id are captured together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_code  <= CODE_W'(CHAR_BLANK);
    end else begin
      r_rsp_valid <= '0;
      if (w_last.valid) begin
        r_rsp_valid <= ONE << w_last.id;
        r_rsp_code  <= rom_char_code;
      end
    end
  end

  // Busy covers the grant edge through the cycle the response strobe is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= w_gnt_valid | w_pipe_any;
    end
  end

  assign gnt         = w_gnt;
  assign rom_char_xy = r_xy;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_code    = r_rsp_code;
  assign busy        = r_busy;

endmodule

// File: tb/tb_char_rom_arbiter.sv
// Scoreboard bench: expected responses are queued at grant time and matched by a monitor.
module tb_char_rom_arbiter;
  import text_pkg::*;

  localparam int N  = 4;
  localparam int AW = CHAR_ADDR_W;
  localparam int CW = CHAR_CODE_W;

  localparam char_rom_pair_t ROM_TAB [5] = '{
    '{xy: 12'h000, code: 7'h46},
    '{xy: 12'h001, code: 7'h4F},
    '{xy: 12'h002, code: 7'h52},
    '{xy: 12'h01a, code: 7'h31},
    '{xy: 12'h0FF, code: 7'h20}
  };

  function automatic logic [CW-1:0] rom_model(input logic [AW-1:0] a);
    logic [CW-1:0] c;
    c = {1'b1, a[5:0]};
    for (int i = 0; i < 5; i++) begin
      if (ROM_TAB[i].xy == a) c = ROM_TAB[i].code;
    end
    return c;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic            en;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    gnt;
  logic [AW-1:0]   rom_xy;
  logic [CW-1:0]   rom_code;
  logic [N-1:0]    rsp_valid;
  logic [CW-1:0]   rsp_code;
  logic            busy;

  logic            en_l3;
  logic [N-1:0]    req_l3;
  logic [N*AW-1:0] addr_l3;
  logic [N-1:0]    gnt_l3;
  logic [AW-1:0]   rom_xy_l3;
  logic [CW-1:0]   rom_code_l3;
  logic [N-1:0]    rsp_valid_l3;
  logic [CW-1:0]   rsp_code_l3;
  logic            busy_l3;

  char_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .CODE_W(CW), .ROM_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .addr(addr), .gnt(gnt),
    .rom_char_xy(rom_xy), .rom_char_code(rom_code),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code), .busy(busy)
  );

  char_rom_arbiter #(.N_REQ(N), .ADDR_W(AW), .CODE_W(CW), .ROM_LAT(3)) u_dut_l3 (
    .clk(clk), .rst_n(rst_n), .en(en_l3), .req(req_l3), .addr(addr_l3), .gnt(gnt_l3),
    .rom_char_xy(rom_xy_l3), .rom_char_code(rom_code_l3),
    .rsp_valid(rsp_valid_l3), .rsp_code(rsp_code_l3), .busy(busy_l3)
  );

  // Registered ROM models: one-cycle and three-cycle read latency.
  logic [CW-1:0] rom1_q;
  logic [CW-1:0] rom3_q [3];
  always @(posedge clk) begin
    rom1_q    <= rom_model(rom_xy);
    rom3_q[0] <= rom_model(rom_xy_l3);
    rom3_q[1] <= rom3_q[0];
    rom3_q[2] <= rom3_q[1];
  end
  assign rom_code    = rom1_q;
  assign rom_code_l3 = rom3_q[2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  logic mon_on = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int           due;
    logic [N-1:0] onehot;
    logic [CW-1:0] code;
  } exp_t;

  exp_t sb [$];
  exp_t mon_e;

  task automatic sb_push(input int id, input logic [AW-1:0] a);
    exp_t e;
    e.due    = cyc + 3;
    e.onehot = N'(1) << id;
    e.code   = rom_model(a);
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (rsp_valid !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got valid=%b code=%h at cycle %0d, want no response",
                   rsp_valid, rsp_code, cyc);
        end else begin
          mon_e = sb.pop_front();
          if (rsp_valid !== mon_e.onehot || rsp_code !== mon_e.code || cyc != mon_e.due) begin
            errors++;
            $display("FAIL rsp_match: got valid=%b code=%h cycle=%0d, want valid=%b code=%h cycle=%0d",
                     rsp_valid, rsp_code, cyc, mon_e.onehot, mon_e.code, mon_e.due);
          end
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        checks++;
        errors++;
        $display("FAIL rsp_missing: got none at cycle %0d, want valid=%b code=%h",
                 cyc, sb[0].onehot, sb[0].code);
        mon_e = sb.pop_front();
      end
    end
  end

  task automatic drive(input logic e, input logic [N-1:0] r, output logic [N-1:0] g);
    @(negedge clk);
    en  = e;
    req = r;
    #1;
    g = gnt;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    @(negedge clk);
    en = 1'b1; req = 4'hF; en_l3 = 1'b1; req_l3 = 4'hF;
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    checks++; if (gnt_l3 !== 4'b0000) begin errors++; $display("FAIL reset_gnt_l3: got %b want 0000", gnt_l3); end
    checks++; if (rom_xy !== 12'h000) begin errors++; $display("FAIL reset_xy: got %h want 000", rom_xy); end
    checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    checks++; if (rsp_code !== 7'h20) begin errors++; $display("FAIL reset_rsp_code: got %h want 20", rsp_code); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(negedge clk);
    req = '0; req_l3 = '0; en_l3 = 1'b0;
    rst_n  = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic test_single();
    logic [N-1:0] g;
    addr[0 +: AW] = 12'h000;
    drive(1'b1, 4'b0001, g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b want 0001", g); end
    sb_push(0, 12'h000);
    drive(1'b1, 4'b0000, g);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    checks++; if (rom_xy !== 12'h000) begin errors++; $display("FAIL single_xy: got %h want 000", rom_xy); end
    repeat (3) @(negedge clk);
    checks++; if (rsp_code !== 7'h46 || rsp_valid !== 4'b0000) begin
      errors++; $display("FAIL single_hold: got code=%h valid=%b want code=46 valid=0000", rsp_code, rsp_valid);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_all_four();
    logic [N-1:0]  g;
    logic [N-1:0]  r;
    logic [AW-1:0] a [4] = '{12'h001, 12'h002, 12'h01a, 12'h0FF};
    do_reset();
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = a[i];
    r = 4'hF;
    for (int i = 0; i < N; i++) begin
      drive(1'b1, r, g);
      checks++; if (g !== (N'(1) << i)) begin errors++; $display("FAIL all4_gnt%0d: got %b want %b", i, g, N'(1) << i); end
      if (i > 0) begin
        checks++; if (rom_xy !== a[i-1]) begin errors++; $display("FAIL all4_xy%0d: got %h want %h", i, rom_xy, a[i-1]); end
      end
      sb_push(i, a[i]);
      r[i] = 1'b0;
    end
    drive(1'b1, 4'b0000, g);
    checks++; if (rom_xy !== a[3]) begin errors++; $display("FAIL all4_xy_last: got %h want %h", rom_xy, a[3]); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [N-1:0] g;
    logic [N-1:0] exp_g;
    addr[0 +: AW]    = 12'h002;
    addr[2*AW +: AW] = 12'h01a;
    drive(1'b1, 4'b0001, g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL fair_c0: got %b want 0001", g); end
    sb_push(0, 12'h002);
    for (int c = 1; c <= 6; c++) begin
      drive(1'b1, 4'b0101, g);
      exp_g = (c % 2 == 1) ? 4'b0100 : 4'b0001;
      checks++; if (g !== exp_g) begin errors++; $display("FAIL fair_c%0d: got %b want %b", c, g, exp_g); end
      if (exp_g == 4'b0100) sb_push(2, 12'h01a);
      else                  sb_push(0, 12'h002);
    end
    drive(1'b1, 4'b0000, g);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_en_low();
    logic [N-1:0] g;
    addr[3*AW +: AW] = 12'h0FF;
    addr[1*AW +: AW] = 12'h000;
    drive(1'b1, 4'b1000, g);
    checks++; if (g !== 4'b1000) begin errors++; $display("FAIL enlow_pre: got %b want 1000", g); end
    sb_push(3, 12'h0FF);
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 4'b0010, g);
      checks++; if (g !== 4'b0000) begin errors++; $display("FAIL enlow_gnt%0d: got %b want 0000", c, g); end
      if (c == 0) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL enlow_busy: got %b want 1", busy); end
      end
    end
    drive(1'b1, 4'b1010, g);
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL enlow_resume: got %b want 0010", g); end
    sb_push(1, 12'h000);
    drive(1'b1, 4'b1000, g);
    checks++; if (g !== 4'b1000) begin errors++; $display("FAIL enlow_next: got %b want 1000", g); end
    sb_push(3, 12'h0FF);
    drive(1'b1, 4'b0000, g);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    logic [N-1:0] g;
    addr[0 +: AW]    = 12'h001;
    addr[1*AW +: AW] = 12'h002;
    addr[3*AW +: AW] = 12'h01a;
    drive(1'b1, 4'b0011, g);
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL mrst_g0: got %b want 0001", g); end
    sb_push(0, 12'h001);
    drive(1'b1, 4'b0010, g);
    checks++; if (g !== 4'b0010) begin errors++; $display("FAIL mrst_g1: got %b want 0010", g); end
    sb_push(1, 12'h002);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'hF;
    sb.delete();
    #1;
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mrst_gnt: got %b want 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b want 0", busy); end
    @(negedge clk);
    req   = '0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy_after: got %b want 0", busy); end
    drive(1'b1, 4'b1000, g);
    checks++; if (g !== 4'b1000) begin errors++; $display("FAIL mrst_new: got %b want 1000", g); end
    sb_push(3, 12'h01a);
    drive(1'b1, 4'b0000, g);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_lat3();
    logic [N-1:0] exp_v;
    logic         exp_b;
    addr_l3[0 +: AW]  = 12'h001;
    addr_l3[AW +: AW] = 12'h01a;
    @(negedge clk);
    en_l3 = 1'b1; req_l3 = 4'b0011;
    #1;
    checks++; if (gnt_l3 !== 4'b0001) begin errors++; $display("FAIL lat3_g0: got %b want 0001", gnt_l3); end
    @(negedge clk);
    req_l3 = 4'b0010;
    #1;
    checks++; if (gnt_l3 !== 4'b0010) begin errors++; $display("FAIL lat3_g1: got %b want 0010", gnt_l3); end
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) begin
        @(negedge clk);
        req_l3 = '0;
      end
      exp_b = (k <= 6);
      exp_v = (k == 5) ? 4'b0001 : (k == 6) ? 4'b0010 : 4'b0000;
      checks++; if (busy_l3 !== exp_b) begin errors++; $display("FAIL lat3_busy_t%0d: got %b want %b", k, busy_l3, exp_b); end
      checks++; if (rsp_valid_l3 !== exp_v) begin errors++; $display("FAIL lat3_valid_t%0d: got %b want %b", k, rsp_valid_l3, exp_v); end
      if (k == 5) begin
        checks++; if (rsp_code_l3 !== 7'h4F) begin errors++; $display("FAIL lat3_code_t5: got %h want 4f", rsp_code_l3); end
      end
      if (k == 6) begin
        checks++; if (rsp_code_l3 !== 7'h31) begin errors++; $display("FAIL lat3_code_t6: got %h want 31", rsp_code_l3); end
      end
    end
    en_l3 = 1'b0;
  endtask

  task automatic test_drain();
    repeat (4) @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL drain: got %0d pending want 0", sb.size()); end
  endtask

  initial begin
    en = 1'b0; req = '0; addr = '0;
    en_l3 = 1'b0; req_l3 = '0; addr_l3 = '0;
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_en_low();
    test_mid_reset();
    test_lat3();
    test_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/char_rom_arbiter.md
Name: char_rom_arbiter

Overview:
Round-robin arbiter that shares one registered-output character ROM port (12-bit char_xy in, 7-bit char_code out) between up to N_REQ text renderers. Examples of renderers: title overlay, score line, mode banner, help text.
Accepts one lookup per cycle and tracks in-flight lookups through the ROM latency. Routes each returned character code back to the requester that issued it.
Sits between the text-render blocks and the char ROM, in the same clock domain as the VGA pipeline.

Parameters:
N_REQ, 4, number of requesters (2..8)
ADDR_W, 12, ROM address width (char_xy)
CODE_W, 7, character code width
ROM_LAT, 1, ROM read latency in cycles from char_xy to char_code (1..3)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  grant enable; 0 = issue no new grants (in-flight responses still delivered)
req  in  N_REQ  per-requester lookup request; level, held until granted
addr  in  N_REQ*ADDR_W  packed request addresses; slice i = requester i
gnt  out  N_REQ  one-hot grant; combinational, same cycle as the accepted request
rom_char_xy  out  ADDR_W  registered address to the ROM
rom_char_code  in  CODE_W  ROM data, valid ROM_LAT cycles after rom_char_xy
rsp_valid  out  N_REQ  one-hot, one-cycle response strobe
rsp_code  out  CODE_W  returned character code; holds its last value between responses
busy  out  1  1 while any lookup is in flight

Behaviour:
- Reset values (async, rst_n=0): gnt=0, rom_char_xy=0, rsp_valid=0, rsp_code=7'h20, busy=0, rr pointer=0, in-flight pipe cleared. gnt is forced 0 while rst_n=0 regardless of req.
- Handshake: transfer for requester i occurs in a cycle where req[i]=1 and gnt[i]=1. The requester may change addr/drop req only after that edge. Dropping req before the grant is legal: no lookup is issued.
- Arbitration: when en=1 and any req is high, grant the first requester with req=1, searching from ptr upward modulo N_REQ. On a grant to i, ptr <= (i+1) mod N_REQ. If no grant is made, ptr is unchanged. At most one grant per cycle, so throughput is 1 lookup/cycle.
- en=0: gnt=0 and ptr is frozen. The pipe keeps draining.
- Address path: on a grant edge, rom_char_xy <= addr slice of the winner. With no grant, rom_char_xy holds its value.
- Tag pipe: a shift register of depth ROM_LAT+1 carries {valid, id[$clog2(N_REQ)-1:0]}. Stage 0 is loaded on the grant edge.
- Response: when the last pipe stage is valid, rsp_code <= rom_char_code and rsp_valid <= onehot(id) for one cycle. Otherwise rsp_valid <= 0.
- Latency: grant in cycle t gives rsp_valid in cycle t+ROM_LAT+2 (t+3 for the default).
- Ordering: responses return in grant order. Back-to-back grants produce back-to-back responses with no bubbles.
- busy = OR of all pipe valid bits, registered so it follows the pipe.
- Mid-operation reset: all in-flight lookups are discarded. No rsp_valid is asserted for pre-reset grants after rst_n deasserts. The first grant after reset goes to the lowest-index active requester (ptr=0).
- Simultaneous requests: fairness guarantee is that a requester holding req high is granted within N_REQ cycles of en=1.
- Width rules: the id width is max(1, $clog2(N_REQ)). Addresses pass through unmodified. No arithmetic is performed on the address or code.

Decomposition:
- Shared package text_pkg holds: CHAR_ADDR_W=12, CHAR_CODE_W=7, CHAR_BLANK=7'h20, and the typedef for the char ROM address/code pair.
- One natural sub-module, rr_arbiter: combinational pick from req, ptr and en, plus the ptr register; outputs one-hot gnt and the binary id.
- The top level holds the address register, tag pipe and response register.

Test Plan:
1. Single lookup, using the solo-mode text ROM model. Reset, then req[0]=1 with addr0=12'h000 in cycle t → gnt[0]=1 in cycle t; rom_char_xy=0 at t+1; rsp_valid=4'b0001 and rsp_code=7'h46 ("F") at t+3.
2. All four requesters request in the same cycle: addr0..3 = 0x001, 0x002, 0x01a, 0x0FF → grants 0,1,2,3 on consecutive cycles; responses 0x4F, 0x52, 0x31, 0x20 with rsp_valid 0001, 0010, 0100, 1000 on consecutive cycles starting at t+3.
3. Fairness: req0 held high continuously, req2 high from cycle 1 → gnt alternates 0,2,0,2. req2 is never starved beyond N_REQ cycles.
4. en=0 with req[1] high for 5 cycles → gnt=0 and no new rsp. Lookups already in flight still respond. On en=1, gnt[1] is asserted the same cycle.
5. rst_n pulsed low 1 cycle after two grants → rsp_valid stays 0 for those grants, busy=0. A new req[3] after release gets gnt[3] and a correct response 3 cycles later.
6. ROM_LAT=3 build, two back-to-back grants → responses at t+5 and t+6 with correct ids and codes. busy=1 from t+1 through t+6.
